// File: rtl/pcie_wr_initiator.sv
// pcie_wr_initiator: FPGA-initiated upstream write engine.
// Turns a command (host byte address, QW count) plus a 64-bit payload stream into
// posted Memory Write TLPs on the pcie_sv transmit pipe.
// Optional build macro PCIE_WR_INIT_ADDR64_EN widens cmdAddr_in to 64 bits and emits
// 4DW headers whenever the upper address word is non-zero.

module pcie_wr_initiator #(
  parameter int unsigned MAX_PAYLOAD_QW = 16,
  parameter bit          EN_SWAP        = 1'b0
) (
  input  logic        pcieClk_in,
  input  logic        pcieRstN_in,
  input  logic [12:0] cfgBusDev_in,
`ifdef PCIE_WR_INIT_ADDR64_EN
  input  logic [63:0] cmdAddr_in,
`else
  input  logic [31:0] cmdAddr_in,
`endif
  input  logic [9:0]  cmdLen_in,
  input  logic        cmdValid_in,
  output logic        cmdReady_out,
  input  logic [63:0] dataData_in,
  input  logic        dataValid_in,
  output logic        dataReady_out,
  output logic [63:0] txData_out,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        busy_out,
  output logic        error_out,
  output logic [31:0] tlpCount_out
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr0 = 2'd1,
    StHdr1 = 2'd2,
    StData = 2'd3
  } state_e;

  // Byte-reverse each 32-bit half of a payload QW.
  function automatic logic [63:0] swap_dw_bytes(input logic [63:0] d);
    return {d[39:32], d[47:40], d[55:48], d[63:56],
            d[7:0],   d[15:8],  d[23:16], d[31:24]};
  endfunction

  state_e      r_state;
  logic [63:0] r_hdr0;
  logic [63:0] r_hdr1;
  logic [9:0]  r_remaining;
  logic        r_error;
  logic [31:0] r_tlp_count;

  logic        w_len_ok;
  logic        w_align_ok;
  logic [13:0] w_end_offset;
  logic        w_page_ok;
  logic        w_cmd_legal;
  logic [9:0]  w_len_dw;
  logic [15:0] w_req_id;
  logic [2:0]  w_fmt;
  logic [31:0] w_dw0;
  logic [31:0] w_dw1;
  logic [63:0] w_hdr1;
  logic [63:0] w_payload;
  logic        w_data_xfer;

  // Command legality: non-empty, within max payload, QW aligned, no 4KB crossing.
  always_comb begin
    w_len_ok     = (cmdLen_in != 10'd0) && (32'(cmdLen_in) <= MAX_PAYLOAD_QW);
    w_align_ok   = (cmdAddr_in[2:0] == 3'b000);
    // End offset within the 4KB page; exactly 4096 means the TLP ends on the boundary.
    w_end_offset = {2'b00, cmdAddr_in[11:0]} + {1'b0, cmdLen_in, 3'b000};
    w_page_ok    = (w_end_offset <= 14'd4096);
    w_cmd_legal  = w_len_ok && w_align_ok && w_page_ok;
  end

  // Header words built from the live command so they can be latched at the handshake.
  always_comb begin
    // 1024 DW wraps to a length field of 0.
    w_len_dw = {cmdLen_in[8:0], 1'b0};
    w_req_id = {cfgBusDev_in, 3'b000};
`ifdef PCIE_WR_INIT_ADDR64_EN
    if (cmdAddr_in[63:32] != 32'h0) begin
      w_fmt  = 3'b011;
      w_hdr1 = {cmdAddr_in[31:2], 2'b00, cmdAddr_in[63:32]};
    end else begin
      w_fmt  = 3'b010;
      w_hdr1 = {32'h0, cmdAddr_in[31:2], 2'b00};
    end
`else
    w_fmt  = 3'b010;
    w_hdr1 = {32'h0, cmdAddr_in[31:2], 2'b00};
`endif
    w_dw0 = {w_fmt, 5'b00000, 8'h00, 6'h00, w_len_dw};
    w_dw1 = {w_req_id, 8'h00, 4'hF, 4'hF};
  end

  // Payload path with optional byte swap.
  always_comb begin
    w_payload   = EN_SWAP ? swap_dw_bytes(dataData_in) : dataData_in;
    w_data_xfer = dataValid_in && txReady_in;
  end

  // Main FSM: command acceptance, header sequencing, payload countdown and statistics.
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_state     <= StIdle;
      r_hdr0      <= 64'h0;
      r_hdr1      <= 64'h0;
      r_remaining <= 10'd0;
      r_error     <= 1'b0;
      r_tlp_count <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmdValid_in) begin
            if (w_cmd_legal) begin
              r_hdr0      <= {w_dw1, w_dw0};
              r_hdr1      <= w_hdr1;
              // Loaded early; only consulted once the headers are out.
              r_remaining <= cmdLen_in;
              r_state     <= StHdr0;
            end else begin
              // Illegal commands are swallowed; only the sticky flag records them.
              r_error <= 1'b1;
            end
          end
        end
        StHdr0: begin
          if (txReady_in) r_state <= StHdr1;
        end
        StHdr1: begin
          if (txReady_in) r_state <= StData;
        end
        StData: begin
          if (w_data_xfer) begin
            r_remaining <= r_remaining - 10'd1;
            if (r_remaining == 10'd1) begin
              r_state     <= StIdle;
              r_tlp_count <= r_tlp_count + 32'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output decode: headers come from registers, payload passes straight through.
  always_comb begin
    cmdReady_out  = 1'b0;
    dataReady_out = 1'b0;
    txData_out    = 64'h0;
    txSOP_out     = 1'b0;
    txEOP_out     = 1'b0;
    txValid_out   = 1'b0;
    unique case (r_state)
      StIdle: begin
        cmdReady_out = 1'b1;
      end
      StHdr0: begin
        txValid_out = 1'b1;
        txSOP_out   = 1'b1;
        txData_out  = r_hdr0;
      end
      StHdr1: begin
        txValid_out = 1'b1;
        txData_out  = r_hdr1;
      end
      StData: begin
        txValid_out   = dataValid_in;
        dataReady_out = txReady_in;
        txData_out    = w_payload;
        txEOP_out     = (r_remaining == 10'd1);
      end
      default: ;
    endcase
  end

  assign busy_out     = (r_state != StIdle);
  assign error_out    = r_error;
  assign tlpCount_out = r_tlp_count;

endmodule
